// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter/sequencer sharing one iterative multiplier
// among NUM_REQ requesters. Each transaction runs IDLE -> START -> BUSY -> DONE
// -> CLEAR. Only one operation is outstanding at a time.
// Optional macro MUL_ARB_TIMEOUT_EN adds a BUSY watchdog that aborts a stuck
// operation after TIMEOUT cycles, returning a zero product with err set.
module mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 40
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        ack,
  output logic [2*DATA_W-1:0]       result,
  output logic                      busy,
  output logic                      err,
  output logic                      mul_op_start,
  output logic                      mul_op_clear,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  input  logic [2*DATA_W-1:0]       mul_result,
  input  logic                      mul_op_done
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Reject configurations outside the supported range at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_nreq
    $error("mul_share_arb: NUM_REQ must be 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mul_share_arb: TIMEOUT must be 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE,
    S_CLEAR
  } state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      ptr_q;
  logic [NUM_REQ-1:0]    grant_q;
  logic [NUM_REQ-1:0]    ack_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  start_q;
  logic                  clear_q;
  logic [DATA_W-1:0]     mul_a_q;
  logic [DATA_W-1:0]     mul_b_q;

  logic [IDX_W-1:0]      sel_d;
  logic                  any_d;
  logic [IDX_W-1:0]      cand;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]            wdog_q;
  logic                  err_q;
`endif

  // Unpacked views of the flattened operand buses.
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
  end

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  // Round-robin pick: scan from ptr+NUM_REQ down to ptr+1 so the nearest
  // requester above the pointer is the last (winning) assignment.
  always_comb begin
    sel_d = '0;
    any_d = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = wrap_idx(int'(ptr_q) + k);
      if (req[cand]) begin
        any_d = 1'b1;
        sel_d = cand;
      end
    end
  end

  // Sequencer FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      grant_q  <= '0;
      ack_q    <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      clear_q  <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      wdog_q   <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_d) begin
            idx_q   <= sel_d;
            mul_a_q <= a_arr[sel_d];
            mul_b_q <= b_arr[sel_d];
            grant_q <= NUM_REQ'(1) << sel_d;
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          start_q <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
          wdog_q  <= '0;
`endif
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (mul_op_done) begin
            result_q <= mul_result;
            ack_q    <= NUM_REQ'(1) << idx_q;
            state_q  <= S_DONE;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (wdog_q == TO_LAST) begin
            // Multiplier never answered: return a zero product flagged as error.
            result_q <= '0;
            ack_q    <= NUM_REQ'(1) << idx_q;
            err_q    <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
`endif
        end
        S_DONE: begin
          ack_q   <= '0;
          grant_q <= '0;
          clear_q <= 1'b1;
          ptr_q   <= idx_q;
`ifdef MUL_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          clear_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant        = grant_q;
  assign ack          = ack_q;
  assign result       = result_q;
  assign busy         = (state_q != S_IDLE);
  assign mul_op_start = start_q;
  assign mul_op_clear = clear_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
`ifdef MUL_ARB_TIMEOUT_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

  // Handshake sanity: start/clear exclusive, grant and ack at most one-hot.
  a_start_clear_excl: assert property (@(posedge clk) disable iff (reset)
    !(mul_op_start && mul_op_clear));
  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant));
  a_ack_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(ack));

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb: directed and randomized checks of mul_share_arb against a
// transaction-level round-robin model plus a latency-programmable multiplier.
module tb_mul_share_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 40;
  localparam int IW = $clog2(N);

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req = '0;
  logic [N-1:0][W-1:0] ra = '0;
  logic [N-1:0][W-1:0] rb = '0;
  logic [N-1:0]        grant, ack;
  logic [2*W-1:0]      result;
  logic                busy, err, mul_op_start, mul_op_clear;
  logic [W-1:0]        mul_a, mul_b;
  logic [2*W-1:0]      mul_result;
  logic                mul_op_done;

  mul_share_arb #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(ra), .req_b(rb),
    .grant(grant), .ack(ack), .result(result), .busy(busy), .err(err),
    .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .mul_op_done(mul_op_done)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Iterative multiplier stand-in: done `lat` cycles after start, or never.
  int          lat = 33;
  bit          never_done = 1'b0;
  logic        mrun;
  int          mcnt;
  logic [63:0] mprod_m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mrun        <= 1'b0;
      mcnt        <= 0;
      mprod_m     <= '0;
      mul_op_done <= 1'b0;
      mul_result  <= '0;
    end else begin
      mul_op_done <= 1'b0;
      if (mul_op_clear) mrun <= 1'b0;
      else if (mul_op_start) begin
        mrun    <= 1'b1;
        mcnt    <= lat - 1;
        mprod_m <= 64'(mul_a) * 64'(mul_b);
      end else if (mrun && !never_done) begin
        if (mcnt == 0) begin
          mul_op_done <= 1'b1;
          mul_result  <= mprod_m;
          mrun        <= 1'b0;
        end else mcnt <= mcnt - 1;
      end
    end
  end

  // Reference: inputs as seen at each rising edge.
  logic [N-1:0]        req_s;
  logic [N-1:0][W-1:0] as_s, bs_s;
  always @(posedge clk) begin
    req_s = req;
    as_s  = ra;
    bs_s  = rb;
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[IW'((p + k) % N)]) return (p + k) % N;
    return -1;
  endfunction

  // Transaction model: 0 = no transaction, 1 = granted, 2 = acked (expect clear).
  int          phase = 0, midx = 0, mptr = N - 1, bcyc = 0, nack = 0;
  bit          was_idle = 1'b0;
  logic        done_q = 1'b0;
  logic [63:0] mprod = '0, last_res = '0;

  always @(negedge clk) begin
    if (reset) begin
      phase    = 0;
      mptr     = N - 1;
      was_idle = 1'b0;
      done_q   = 1'b0;
    end else begin
      chk("start_clear_excl", 64'(mul_op_start & mul_op_clear), 64'(0));
      chk("grant_onehot0", 64'($onehot0(grant)), 64'(1));
      chk("ack_onehot0", 64'($onehot0(ack)), 64'(1));
      case (phase)
        0: begin
          chk("idle_clear", 64'(mul_op_clear), 64'(0));
          chk("idle_ack", 64'(ack), 64'(0));
          if (was_idle && req_s != '0) chk("start_latency", 64'(mul_op_start), 64'(1));
          if (mul_op_start) begin
            midx = rr_pick(req_s, mptr);
            if (midx < 0) chk("start_without_req", 64'(mul_op_start), 64'(0));
            else begin
              chk("rr_grant", 64'(grant), 64'(1) << midx);
              chk("latched_a", 64'(mul_a), 64'(as_s[IW'(midx)]));
              chk("latched_b", 64'(mul_b), 64'(bs_s[IW'(midx)]));
              chk("start_busy", 64'(busy), 64'(1));
              mprod    = 64'(as_s[IW'(midx)]) * 64'(bs_s[IW'(midx)]);
              phase    = 1;
              bcyc     = 0;
              was_idle = 1'b0;
            end
          end else begin
            chk("idle_grant", 64'(grant), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
            was_idle = 1'b1;
          end
        end
        1: begin
          bcyc++;
          chk("held_grant", 64'(grant), 64'(1) << midx);
          chk("single_start", 64'(mul_op_start), 64'(0));
          chk("busy_clear", 64'(mul_op_clear), 64'(0));
          chk("busy_flag", 64'(busy), 64'(1));
          if (ack != '0) begin
            nack++;
            chk("ack_idx", 64'(ack), 64'(1) << midx);
`ifdef MUL_ARB_TIMEOUT_EN
            if (never_done) begin
              chk("to_err", 64'(err), 64'(1));
              chk("to_result", result, 64'(0));
              chk("to_cycles", 64'(bcyc), 64'(TO + 1));
              last_res = '0;
            end else
`endif
            begin
              chk("ack_err", 64'(err), 64'(0));
              chk("ack_result", result, mprod);
              chk("ack_latency", 64'(done_q), 64'(1));
              last_res = mprod;
            end
            phase = 2;
          end
        end
        default: begin
          chk("clear_pulse", 64'(mul_op_clear), 64'(1));
          chk("clear_grant", 64'(grant), 64'(0));
          chk("clear_ack", 64'(ack), 64'(0));
          chk("clear_err", 64'(err), 64'(0));
          chk("clear_start", 64'(mul_op_start), 64'(0));
          chk("result_hold", result, last_res);
          mptr     = midx;
          phase    = 0;
          was_idle = 1'b0;
        end
      endcase
      done_q = mul_op_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int i, input int bound);
    int n = 0;
    do begin tick(); n++; end while (!ack[IW'(i)] && n < bound);
    if (!ack[IW'(i)]) chk("ack_wait", 64'(ack), 64'(1) << i);
  endtask

  task automatic wait_grant(input int i, input int bound);
    int n = 0;
    do begin tick(); n++; end while (!grant[IW'(i)] && n < bound);
    if (!grant[IW'(i)]) chk("grant_wait", 64'(grant), 64'(1) << i);
  endtask

  task automatic wait_any_ack(input int bound, output int idx);
    int n = 0;
    idx = -1;
    do begin tick(); n++; end while (ack == '0 && n < bound);
    if (ack == '0) chk("any_ack_wait", 64'(ack != '0), 64'(1));
    for (int i = 0; i < N; i++) if (ack[IW'(i)]) idx = i;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_grant"}, 64'(grant), 64'(0));
    chk({pfx, "_ack"}, 64'(ack), 64'(0));
    chk({pfx, "_result"}, result, 64'(0));
    chk({pfx, "_busy"}, 64'(busy), 64'(0));
    chk({pfx, "_err"}, 64'(err), 64'(0));
    chk({pfx, "_start"}, 64'(mul_op_start), 64'(0));
    chk({pfx, "_clear"}, 64'(mul_op_clear), 64'(0));
    chk({pfx, "_mul_a"}, 64'(mul_a), 64'(0));
    chk({pfx, "_mul_b"}, 64'(mul_b), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int ord [5] = '{0, 1, 2, 3, 0};
    int idx, n0, n;
    reset = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Single request, slow multiplier.
    lat = 33; ra[1] = 3; rb[1] = 5; req[1] = 1'b1;
    wait_ack(1, 200);
    chk("single_result", result, 64'h0000_0000_0000_000F);
    req[1] = 1'b0;
    tick();
    chk("single_clear", 64'(mul_op_clear), 64'(1));
    repeat (2) tick();

    // Reset while BUSY, then all four held: order 0,1,2,3,0.
    for (int i = 0; i < N; i++) begin ra[i] = W'(i + 1); rb[i] = 32'd10; end
    lat = 5; req = '1;
    wait_grant(1, 50);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_any_ack(200, idx);
      chk("rr_order", 64'(idx), 64'(ord[k]));
      chk("rr_result", result, 64'((ord[k] + 1) * 10));
    end
    req = '0;
    repeat (3) tick();

    // Operand change after grant is ignored.
    ra[2] = 7; rb[2] = 6; req[2] = 1'b1;
    wait_grant(2, 50);
    tick();
    ra[2] = 0;
    wait_ack(2, 200);
    chk("late_operand_result", result, 64'd42);
    req[2] = 1'b0;
    repeat (3) tick();

    // Request dropped after grant still completes; next grant only after CLEAR.
    ra[3] = 9; rb[3] = 11; req[3] = 1'b1;
    wait_grant(3, 50);
    repeat (2) tick();
    req[3] = 1'b0; ra[1] = 2; rb[1] = 3; req[1] = 1'b1;
    wait_ack(3, 200);
    chk("drop_result", result, 64'd99);
    chk("drop_grant_done", 64'(grant), 64'h8);
    tick();
    chk("drop_clear", 64'(mul_op_clear), 64'(1));
    chk("drop_grant_clear", 64'(grant), 64'(0));
    wait_ack(1, 200);
    chk("after_drop_result", result, 64'd6);
    req[1] = 1'b0;
    repeat (3) tick();

    // Multiplier that never completes.
    never_done = 1'b1; ra[0] = 5; rb[0] = 5; req[0] = 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
    wait_ack(0, TO + 20);
    chk("timeout_err", 64'(err), 64'(1));
    chk("timeout_result", result, 64'(0));
    req[0] = 1'b0; never_done = 1'b0;
    tick();
    chk("timeout_clear", 64'(mul_op_clear), 64'(1));
    repeat (3) tick();
`else
    n0 = nack;
    repeat (TO + 40) tick();
    chk("stuck_busy", 64'(busy), 64'(1));
    chk("stuck_no_ack", 64'(nack - n0), 64'(0));
    reset = 1'b1;
    tick();
    req = '0; never_done = 1'b0; reset = 1'b0;
    tick();
`endif

    // Randomized traffic.
    n0 = nack;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) begin
          ra[i] = $urandom; rb[i] = $urandom; req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 15) == 0) ra[i] = $urandom;
      end
      if ($urandom_range(0, 9) == 0) lat = $urandom_range(1, 40);
    end
    n = 0;
    while ((req != '0 || busy) && n < 2000) begin
      tick();
      for (int i = 0; i < N; i++) if (req[i] && ack[i]) req[i] = 1'b0;
      n++;
    end
    chk("drain_idle", 64'(busy), 64'(0));
    chk("random_progress", 64'(nack - n0 > 20), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
